pixel_fetch: RTL

PIXEL_FETCH -- requirements
Module: pixel_fetch

---
 rtl/pixel_fetch_pkg.sv | 33 +++
 rtl/pixel_fetch_buf.sv | 75 +++++++
 rtl/pixel_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared constants and types for the pixel fetch path: display geometry,
// address-FIFO word layout, pixel width and the return-pipeline tag.
package pixel_fetch_pkg;

    localparam int DISPLAY_WIDTH    = 800;
    localparam int DISPLAY_HEIGHT   = 480;
    localparam int PIXELS_PER_FRAME = DISPLAY_WIDTH * DISPLAY_HEIGHT;

    localparam int ADDR_VALID_BIT = 19;
    localparam int ADDR_W         = 19;
    localparam int WORD_W         = 20;
    localparam int PIXEL_W        = 16;

    localparam int PIX_CNT_W    = 19;
    localparam int PRIME_CYCLES = 16;
    localparam int PRIME_CNT_W  = 5;

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_t;

    // One slot of the memory-return pipeline
    typedef struct packed {
        logic live;
        logic blank;
    } ret_tag_t;

    function automatic logic addr_word_valid(input logic [WORD_W-1:0] word);
        return word[ADDR_VALID_BIT];
    endfunction

endpackage

// File: rtl/pixel_fetch_buf.sv
// Show-ahead pixel FIFO: the head entry is always visible on rd_data.
module pixel_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Status flags, qualified strobes and the show-ahead head entry
    always_comb begin
        empty   = (count_r == {CNT_W{1'b0}});
        full    = (count_r == CNT_W'(DEPTH));
        wr_ok_s = wr_en && (!full || rd_en);
        rd_ok_s = rd_en && !empty;
        rd_data = mem_r[rd_ptr_r];
        count_o = count_r;
    end

    // Storage array; a write when full is accepted only alongside a read
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Read/write pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous read and write leave it unchanged
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fetch.sv
// Pixel fetch: pops pixel addresses from a FIFO, reads pixel memory, and
// feeds a show-ahead buffer to the display. A credit counter bounds
// outstanding reads to the buffer space, so the buffer cannot overflow.
module pixel_fetch
    import pixel_fetch_pkg::*;
#(
    parameter int                 READ_LATENCY = 2,
    parameter int                 BUF_DEPTH    = 4,
    parameter logic [PIXEL_W-1:0] BLANK_PIXEL  = 16'h0000,
    parameter int                 FRAME_PIXELS = PIXELS_PER_FRAME
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [WORD_W-1:0]   iADDRESS,
    input  logic                iREADY_N,
    output logic                oREAD,
    output logic [ADDR_W-1:0]   oMEM_ADDR,
    output logic                oMEM_RD,
    input  logic [PIXEL_W-1:0]  iMEM_DATA,
    input  logic                iDISP_REQ,
    output logic [PIXEL_W-1:0]  oPIXEL,
    output logic                oPIXEL_VALID,
    output logic                oUNDERFLOW,
    output logic                oFRAME_END
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [PIX_CNT_W-1:0] FRAME_LAST = PIX_CNT_W'(FRAME_PIXELS - 1);

    fetch_state_t            state_r;
    fetch_state_t            state_nxt_s;
    logic [PRIME_CNT_W-1:0]  prime_cnt_r;
    logic                    fetch_en_r;
    logic                    pop_d_r;
    logic [CNT_W-1:0]        inflight_r;
    logic [CNT_W:0]          credit_used_s;
    logic [PIX_CNT_W-1:0]    pix_cnt_r;
    ret_tag_t                req_tag_s;
    ret_tag_t                ret_pipe_r [READ_LATENCY];
    logic                    buf_wr_s;
    logic [PIXEL_W-1:0]      buf_wr_data_s;
    logic [PIXEL_W-1:0]      buf_head_s;
    logic [CNT_W-1:0]        buf_count_s;
    logic                    buf_empty_s;
    logic                    buf_full_s;
    logic                    running_s;
    logic                    pop_s;

    pixel_fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_buf (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .wr_en   (buf_wr_s),
        .wr_data (buf_wr_data_s),
        .rd_en   (pop_s),
        .rd_data (buf_head_s),
        .count_o (buf_count_s),
        .empty   (buf_empty_s),
        .full    (buf_full_s)
    );

    // Keeps oREAD low while in reset and for the first edge after release
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_en_r <= 1'b0;
        end else begin
            fetch_en_r <= 1'b1;
        end
    end

    // Pop only if the returning pixel has a guaranteed slot; a same-cycle display pop frees one
    always_comb begin
        credit_used_s = (CNT_W+1)'(buf_count_s) + (CNT_W+1)'(inflight_r) - (CNT_W+1)'(pop_s);
        if (fetch_en_r && !iREADY_N && (credit_used_s < (CNT_W+1)'(BUF_DEPTH))) begin
            oREAD = 1'b1;
        end else begin
            oREAD = 1'b0;
        end
    end

    // Remembers that the word on iADDRESS this cycle was popped last cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pop_d_r <= 1'b0;
        end else begin
            pop_d_r <= oREAD;
        end
    end

    // Memory request from the popped word; invalid words become blank tags instead
    always_comb begin
        req_tag_s.live  = pop_d_r;
        req_tag_s.blank = ~addr_word_valid(iADDRESS);
        if (pop_d_r) begin
            oMEM_RD   = addr_word_valid(iADDRESS);
            oMEM_ADDR = iADDRESS[ADDR_W-1:0];
        end else begin
            oMEM_RD   = 1'b0;
            oMEM_ADDR = {ADDR_W{1'b0}};
        end
    end

    // Return pipeline tracks each request until its data is on iMEM_DATA
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                ret_pipe_r[i] <= '{live: 1'b0, blank: 1'b0};
            end
        end else begin
            ret_pipe_r[0] <= req_tag_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                ret_pipe_r[i] <= ret_pipe_r[i-1];
            end
        end
    end

    // Pipeline exit writes either the memory data or the blank colour
    always_comb begin
        buf_wr_s = ret_pipe_r[READ_LATENCY-1].live;
        if (ret_pipe_r[READ_LATENCY-1].blank) begin
            buf_wr_data_s = BLANK_PIXEL;
        end else begin
            buf_wr_data_s = iMEM_DATA;
        end
    end

    // Outstanding reads: up on pop, down on buffer write
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            case ({oREAD, buf_wr_s})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_PRIME;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Cycles spent priming, bounding how long the display waits
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prime_cnt_r <= {PRIME_CNT_W{1'b0}};
        end else if (state_r == ST_PRIME) begin
            prime_cnt_r <= prime_cnt_r + PRIME_CNT_W'(1);
        end else begin
            prime_cnt_r <= prime_cnt_r;
        end
    end

    // FSM next state: leave PRIME once the buffer is full or the prime window ends
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_PRIME: begin
                if (buf_full_s || (prime_cnt_r == PRIME_CNT_W'(PRIME_CYCLES - 1))) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PRIME;
                end
            end
            ST_RUN:   state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_PRIME;
        endcase
    end

    // FSM outputs: display handshake, underflow and frame marker
    always_comb begin
        case (state_r)
            ST_RUN:   running_s = 1'b1;
            ST_PRIME: running_s = 1'b0;
            default:  running_s = 1'b0;
        endcase
        oPIXEL_VALID = running_s && !buf_empty_s;
        pop_s        = running_s && iDISP_REQ && !buf_empty_s;
        oUNDERFLOW   = running_s && iDISP_REQ && buf_empty_s && !buf_wr_s;
        if (oPIXEL_VALID) begin
            oPIXEL = buf_head_s;
        end else begin
            oPIXEL = BLANK_PIXEL;
        end
        oFRAME_END = pop_s && (pix_cnt_r == FRAME_LAST);
    end

    // Delivered-pixel position within the frame
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_cnt_r <= {PIX_CNT_W{1'b0}};
        end else if (pop_s) begin
            if (pix_cnt_r == FRAME_LAST) begin
                pix_cnt_r <= {PIX_CNT_W{1'b0}};
            end else begin
                pix_cnt_r <= pix_cnt_r + PIX_CNT_W'(1);
            end
        end else begin
            pix_cnt_r <= pix_cnt_r;
        end
    end

endmodule
